sprite_compositor: RTL
======================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter SPRITE_SIZE, default 64: sprite width and height in pixels (power of two, 2..256).
REQ-002 Parameter BG_COLOR, default 12'h000: colour driven where the sprite is absent or transparent.
REQ-003 Parameter TRANSPARENT, default 12'hF0F: ROM colour treated as see-through.
REQ-004 clk  in  1  pixel clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 h_count  in  10  raster column from the timing generator.
REQ-007 v_count  in  10  raster row from the timing generator.
REQ-008 video_on  in  1  active-display flag aligned with h_count/v_count.
REQ-009 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-010 pos_load  in  1  request to stage a new sprite position.
REQ-011 pos_x  in  11  signed sprite left edge, two's complement.
REQ-012 pos_y  in  11  signed sprite top edge, two's complement.
REQ-013 pos_ack  out  1  one-cycle acknowledge of a captured pos_load.
REQ-014 rom_row  out  11  sprite-local row to the sprite ROM.
REQ-015 rom_column  out  11  sprite-local column to the sprite ROM.
REQ-016 rom_q  in  12  combinational ROM colour for rom_row/rom_column (RGB 4:4:4).
REQ-017 rgb_out  out  12  composited pixel colour.
REQ-018 video_on_out  out  1  video_on delayed to align with rgb_out.
REQ-019 hit_out  out  1  high when rgb_out comes from a non-transparent sprite pixel.

Function
REQ-020 Position staging FSM SHALL have states EMPTY and PENDING; shadow registers hold the staged pos_x/pos_y.
REQ-021 pos_load in either state SHALL capture pos_x/pos_y into shadow, pulse pos_ack the next cycle, and go to PENDING; a later load overwrites an earlier unapplied one.
REQ-022 frame_start in PENDING SHALL copy shadow to the active position registers and go to EMPTY; in EMPTY it SHALL leave the active position unchanged.
REQ-023 Simultaneous pos_load and frame_start in PENDING SHALL apply the old shadow to active, capture the new values into shadow, and remain PENDING.
REQ-024 Stage 1 SHALL compute local_col = h_count - active_x and local_row = v_count - active_y in 12-bit signed arithmetic, with counts zero-extended and positions sign-extended.
REQ-025 In-bounds SHALL mean 0 <= local_col < SPRITE_SIZE and 0 <= local_row < SPRITE_SIZE; partially off-screen sprites (negative position) SHALL clip correctly.
REQ-026 rom_row/rom_column SHALL be registered: the low 11 bits of local_row/local_col when in bounds, otherwise 0.
REQ-027 Stage 2 SHALL register rgb_out = rom_q when stage-1 in-bounds, stage-1 video_on and rom_q != TRANSPARENT; BG_COLOR when video_on and not a hit; 12'h000 when video_on is low.
REQ-028 Latency from h_count/v_count/video_on to rgb_out/video_on_out/hit_out SHALL be exactly 2 clocks; throughput one pixel per clock.
REQ-029 hit_out SHALL be high only in cycles where rgb_out is taken from rom_q.
REQ-030 A position change SHALL become visible only on the first pixel after the frame_start that applies it; no tearing mid-frame.

Reset
REQ-031 rst SHALL asynchronously force state EMPTY, shadow and active positions to 0, pos_ack 0, rom_row/rom_column 0, rgb_out 12'h000, video_on_out 0, hit_out 0.
REQ-032 A pos_load coincident with rst SHALL be discarded; reset mid-frame SHALL flush both pipeline stages.

Structure
REQ-033 A shared package SHALL hold the colour typedef (12-bit RGB), signed coordinate typedef (11-bit), staging-state enum, and colour constants BG_COLOR and TRANSPARENT defaults.
REQ-034 One sub-module sprite_pos_stage SHALL implement REQ-020..REQ-023; the sprite ROM stays external.

Verification
REQ-035 Reset, load pos (100,100), pulse frame_start, drive h=100,v=100 with video_on -> rom_row=0, rom_column=0 after 1 clk; rgb_out=rom_q after 2 clks, hit_out=1.
REQ-036 Active pos (-10,-10), drive h=0,v=0 -> rom_row=10, rom_column=10; drive h=54,v=0 (SIZE 64) -> out of bounds, rgb_out=BG_COLOR, hit_out=0.
REQ-037 ROM model returns 12'hF0F at pixel under test -> rgb_out=BG_COLOR, hit_out=0; video_on=0 anywhere -> rgb_out=12'h000.
REQ-038 Load (50,50) mid-frame without frame_start -> pixel (50,50) still uses old position; after frame_start -> hit at (50,50); pos_ack exactly one pulse per load.
REQ-039 pos_load and frame_start same cycle while PENDING with (20,20), new (30,30) -> active=(20,20), state PENDING; next frame_start -> active=(30,30).
REQ-040 Assert rst while PENDING with pipeline full -> all outputs 0 immediately, state EMPTY, active (0,0).

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// Shared types and colour defaults for the sprite compositor.
// Colour is 12-bit RGB 4:4:4; positions are 11-bit signed.
package sprite_compositor_pkg;

  typedef logic [11:0] color_t;
  typedef logic signed [10:0] coord_t;

  typedef enum logic [0:0] {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } stage_state_t;

  localparam color_t BG_COLOR_DEF    = 12'h000;
  localparam color_t TRANSPARENT_DEF = 12'hF0F;

endpackage

// File: rtl/sprite_compositor_pos_stage.sv
// Double-buffered sprite position: loads land in a shadow copy
// and only reach the active copy on a frame boundary.
module sprite_pos_stage
  import sprite_compositor_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   pos_load,
  input  logic   frame_start,
  input  coord_t pos_x,
  input  coord_t pos_y,
  output logic   pos_ack,
  output coord_t active_x,
  output coord_t active_y
);

  stage_state_t state_q, state_d;
  coord_t shadow_x_q, shadow_x_d;
  coord_t shadow_y_q, shadow_y_d;
  coord_t active_x_q, active_x_d;
  coord_t active_y_q, active_y_d;
  logic   ack_q, ack_d;

  always_comb begin
    state_d    = state_q;
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    active_x_d = active_x_q;
    active_y_d = active_y_q;
    ack_d      = pos_load;
    // apply first so a same-cycle load lands in the freed shadow
    if (frame_start && state_q == ST_PENDING) begin
      active_x_d = shadow_x_q;
      active_y_d = shadow_y_q;
      state_d    = ST_EMPTY;
    end
    if (pos_load) begin
      shadow_x_d = pos_x;
      shadow_y_d = pos_y;
      state_d    = ST_PENDING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      shadow_x_q <= '0;
      shadow_y_q <= '0;
      active_x_q <= '0;
      active_y_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      active_x_q <= active_x_d;
      active_y_q <= active_y_d;
      ack_q      <= ack_d;
    end
  end

  assign pos_ack  = ack_q;
  assign active_x = active_x_q;
  assign active_y = active_y_q;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite overlay: stage 1 maps raster to sprite-local
// ROM address, stage 2 picks ROM colour or background.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int     SPRITE_SIZE = 64,
  parameter color_t BG_COLOR    = BG_COLOR_DEF,
  parameter color_t TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   h_count,
  input  logic [9:0]   v_count,
  input  logic         video_on,
  input  logic         frame_start,
  input  logic         pos_load,
  input  logic [10:0]  pos_x,
  input  logic [10:0]  pos_y,
  output logic         pos_ack,
  output logic [10:0]  rom_row,
  output logic [10:0]  rom_column,
  input  logic [11:0]  rom_q,
  output logic [11:0]  rgb_out,
  output logic         video_on_out,
  output logic         hit_out
);

  localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);

  coord_t active_x, active_y;

  sprite_pos_stage u_pos (
    .clk         (clk),
    .rst         (rst),
    .pos_load    (pos_load),
    .frame_start (frame_start),
    .pos_x       (coord_t'(pos_x)),
    .pos_y       (coord_t'(pos_y)),
    .pos_ack     (pos_ack),
    .active_x    (active_x),
    .active_y    (active_y)
  );

  logic signed [11:0] local_col, local_row;
  logic        in_bounds;
  logic [10:0] rom_row_q, rom_row_d;
  logic [10:0] rom_col_q, rom_col_d;
  logic        inb1_q, inb1_d;
  logic        vid1_q, vid1_d;

  always_comb begin
    local_col = $signed({2'b00, h_count})
              - $signed({active_x[10], active_x});
    local_row = $signed({2'b00, v_count})
              - $signed({active_y[10], active_y});
    // sign bit set means left of / above the sprite
    in_bounds = !local_col[11] && !local_row[11]
             && (local_col[10:0] < SIZE11)
             && (local_row[10:0] < SIZE11);
    rom_row_d = in_bounds ? local_row[10:0] : '0;
    rom_col_d = in_bounds ? local_col[10:0] : '0;
    inb1_d    = in_bounds;
    vid1_d    = video_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_row_q <= '0;
      rom_col_q <= '0;
      inb1_q    <= 1'b0;
      vid1_q    <= 1'b0;
    end else begin
      rom_row_q <= rom_row_d;
      rom_col_q <= rom_col_d;
      inb1_q    <= inb1_d;
      vid1_q    <= vid1_d;
    end
  end

  assign rom_row    = rom_row_q;
  assign rom_column = rom_col_q;

  color_t rgb_q, rgb_d;
  logic   vid2_q, vid2_d;
  logic   hit_q, hit_d;

  always_comb begin
    hit_d  = vid1_q && inb1_q && (rom_q != TRANSPARENT);
    vid2_d = vid1_q;
    rgb_d  = '0;
    if (hit_d)       rgb_d = rom_q;
    else if (vid1_q) rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q  <= '0;
      vid2_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      vid2_q <= vid2_d;
      hit_q  <= hit_d;
    end
  end

  assign rgb_out      = rgb_q;
  assign video_on_out = vid2_q;
  assign hit_out      = hit_q;

endmodule
